// File: rtl/rv16_regfile_write_arbiter.sv
// rv16_regfile_write_arbiter: round-robin arbiter sharing the regfile write port, plus a RAW busy scoreboard.
// Defining RV16_WARB_PERF_EN adds a saturating conflict_count output.
module rv16_regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              rv16_warb_clock,
  input  logic              rv16_warb_reset,
  input  logic              req_a_valid,
  input  logic [ADDR_W-1:0] req_a_addr,
  input  logic [DATA_W-1:0] req_a_data,
  output logic              req_a_ready,
  input  logic              req_b_valid,
  input  logic [ADDR_W-1:0] req_b_addr,
  input  logic [DATA_W-1:0] req_b_data,
  output logic              req_b_ready,
  input  logic              mark_valid,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic [ADDR_W-1:0] rs1_addr_in,
  input  logic [ADDR_W-1:0] rs2_addr_in,
  output logic              hazard_stall,
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic [DATA_W-1:0] rd_data_out,
`ifdef RV16_WARB_PERF_EN
  output logic [15:0]       conflict_count,
`endif
  output logic [15:0]       busy_vec
);
  typedef enum logic {PRIO_A, PRIO_B} prio_t;
  prio_t             r_prio, w_prio_nxt;
  logic              w_grant_a, w_grant_b, w_xfer;
  logic [ADDR_W-1:0] w_addr, r_rd_addr;
  logic [DATA_W-1:0] w_data, r_rd_data;
  logic [15:0]       r_busy, w_busy_nxt, w_clr, w_set;
  always_ff @(posedge rv16_warb_clock) begin
    if (rv16_warb_reset) r_prio <= PRIO_A;
    else r_prio <= w_prio_nxt;
  end
  always_comb begin
    w_grant_a  = req_a_valid && (!req_b_valid || r_prio == PRIO_A) && !rv16_warb_reset;
    w_grant_b  = req_b_valid && (!req_a_valid || r_prio == PRIO_B) && !rv16_warb_reset;
    w_prio_nxt = (req_a_valid && req_b_valid) ? ((r_prio == PRIO_A) ? PRIO_B : PRIO_A) : r_prio;
    w_xfer     = w_grant_a || w_grant_b;
    w_addr     = w_grant_a ? req_a_addr : req_b_addr;
    w_data     = w_grant_a ? req_a_data : req_b_data;
    w_clr      = w_xfer ? (16'(1) << w_addr) : 16'h0;
    w_set      = mark_valid ? (16'(1) << mark_addr) : 16'h0;
    // set after clear so a new producer marked this cycle keeps the bit
    w_busy_nxt = ((r_busy & ~w_clr) | w_set) & 16'hFFFE;
  end
  always_ff @(posedge rv16_warb_clock) begin
    if (rv16_warb_reset) begin
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_busy    <= '0;
    end else begin
      r_rd_addr <= w_xfer ? w_addr : '0;
      r_rd_data <= w_xfer ? w_data : r_rd_data;
      r_busy    <= w_busy_nxt;
    end
  end
`ifdef RV16_WARB_PERF_EN
  logic [15:0] r_conflict;
  always_ff @(posedge rv16_warb_clock) begin
    if (rv16_warb_reset) r_conflict <= '0;
    else if (req_a_valid && req_b_valid && r_conflict != 16'hFFFF) r_conflict <= r_conflict + 16'd1;
  end
  assign conflict_count = r_conflict;
`endif
  assign req_a_ready  = w_grant_a;
  assign req_b_ready  = w_grant_b;
  assign hazard_stall = r_busy[rs1_addr_in] | r_busy[rs2_addr_in];
  assign rd_addr_out  = r_rd_addr;
  assign rd_data_out  = r_rd_data;
  assign busy_vec     = r_busy;
endmodule

// File: tb/tb_rv16_regfile_write_arbiter.sv
// tb_rv16_regfile_write_arbiter: directed vector table plus an alternation sequence.
module tb_rv16_regfile_write_arbiter;
  logic clk = 0, rst, av, bv, mv, ra, rb, stall;
  logic [3:0] aa, ba, ma, rs1, rs2, rd_addr;
  logic [15:0] ad, bd, rd_data, busy;
`ifdef RV16_WARB_PERF_EN
  logic [15:0] cc;
`endif
  int n_pass = 0, n_tot = 0;
  always #5 clk = ~clk;
  rv16_regfile_write_arbiter dut (
    .rv16_warb_clock(clk), .rv16_warb_reset(rst),
    .req_a_valid(av), .req_a_addr(aa), .req_a_data(ad), .req_a_ready(ra),
    .req_b_valid(bv), .req_b_addr(ba), .req_b_data(bd), .req_b_ready(rb),
    .mark_valid(mv), .mark_addr(ma), .rs1_addr_in(rs1), .rs2_addr_in(rs2),
    .hazard_stall(stall), .rd_addr_out(rd_addr), .rd_data_out(rd_data),
`ifdef RV16_WARB_PERF_EN
    .conflict_count(cc),
`endif
    .busy_vec(busy));
  typedef struct {
    logic rst, av; logic [3:0] aa; logic [15:0] ad;
    logic bv; logic [3:0] ba; logic [15:0] bd;
    logic mv; logic [3:0] ma, rs1, rs2;
    logic era, erb, est; logic [3:0] eaddr; logic [15:0] edata, ebusy;
  } vec_t;
  vec_t tv[19];
  function automatic vec_t mk(logic r, logic a_v, logic [3:0] a_a, logic [15:0] a_d,
                              logic b_v, logic [3:0] b_a, logic [15:0] b_d,
                              logic m_v, logic [3:0] m_a, logic [3:0] s1, logic [3:0] s2,
                              logic e_ra, logic e_rb, logic e_st,
                              logic [3:0] e_ad, logic [15:0] e_d, logic [15:0] e_b);
    vec_t v;
    v.rst = r; v.av = a_v; v.aa = a_a; v.ad = a_d; v.bv = b_v; v.ba = b_a; v.bd = b_d;
    v.mv = m_v; v.ma = m_a; v.rs1 = s1; v.rs2 = s2; v.era = e_ra; v.erb = e_rb; v.est = e_st;
    v.eaddr = e_ad; v.edata = e_d; v.ebusy = e_b;
    return v;
  endfunction
  task automatic chk(string name, int step, logic [15:0] act, logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
  endtask
  initial begin
    //            rst av aa  ad       bv ba bd       mv ma rs1 rs2  ra rb st  addr data     busy
    tv[0]  = mk(1, 1, 3, 16'h1234, 0, 0, 16'h0,    0, 0, 0, 0,   0, 0, 0,  0, 16'h0,    16'h0);
    tv[1]  = mk(0, 1, 3, 16'h1234, 0, 0, 16'h0,    0, 0, 0, 0,   1, 0, 0,  3, 16'h1234, 16'h0);
    tv[2]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0,   0, 0, 0,  0, 16'h1234, 16'h0);
    tv[3]  = mk(0, 1, 5, 16'h0A05, 1, 6, 16'h0B06, 0, 0, 0, 0,   1, 0, 0,  5, 16'h0A05, 16'h0);
    tv[4]  = mk(0, 0, 0, 16'h0,    1, 6, 16'h0B06, 0, 0, 0, 0,   0, 1, 0,  6, 16'h0B06, 16'h0);
    tv[5]  = mk(0, 1, 5, 16'h0A15, 1, 6, 16'h0B16, 0, 0, 0, 0,   0, 1, 0,  6, 16'h0B16, 16'h0);
    tv[6]  = mk(0, 1, 5, 16'h0A15, 1, 6, 16'h0B16, 0, 0, 0, 0,   1, 0, 0,  5, 16'h0A15, 16'h0);
    tv[7]  = mk(0, 1, 5, 16'h0A15, 1, 6, 16'h0B16, 0, 0, 0, 0,   0, 1, 0,  6, 16'h0B16, 16'h0);
    tv[8]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 7, 7, 0,   0, 0, 0,  0, 16'h0B16, 16'h0080);
    tv[9]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 7, 0,   0, 0, 1,  0, 16'h0B16, 16'h0080);
    tv[10] = mk(0, 0, 0, 16'h0,    1, 7, 16'h7777, 0, 0, 7, 0,   0, 1, 1,  7, 16'h7777, 16'h0);
    tv[11] = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 7, 0,   0, 0, 0,  0, 16'h7777, 16'h0);
    tv[12] = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 9, 0, 0,   0, 0, 0,  0, 16'h7777, 16'h0200);
    tv[13] = mk(0, 1, 9, 16'h9999, 0, 0, 16'h0,    1, 9, 0, 9,   1, 0, 1,  9, 16'h9999, 16'h0200);
    tv[14] = mk(0, 1, 9, 16'h9A9A, 0, 0, 16'h0,    0, 0, 0, 9,   1, 0, 1,  9, 16'h9A9A, 16'h0);
    tv[15] = mk(0, 1, 0, 16'hBEEF, 0, 0, 16'h0,    1, 0, 0, 0,   1, 0, 0,  0, 16'hBEEF, 16'h0);
    tv[16] = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 4, 0, 0,   0, 0, 0,  0, 16'hBEEF, 16'h0010);
    tv[17] = mk(1, 1, 4, 16'h4444, 0, 0, 16'h0,    0, 0, 4, 0,   0, 0, 1,  0, 16'h0,    16'h0);
    tv[18] = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 4, 0,   0, 0, 0,  0, 16'h0,    16'h0);
    rst = 1; av = 0; aa = 0; ad = 0; bv = 0; ba = 0; bd = 0; mv = 0; ma = 0; rs1 = 0; rs2 = 0;
    @(posedge clk);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = tv[i].rst; av = tv[i].av; aa = tv[i].aa; ad = tv[i].ad;
      bv = tv[i].bv; ba = tv[i].ba; bd = tv[i].bd;
      mv = tv[i].mv; ma = tv[i].ma; rs1 = tv[i].rs1; rs2 = tv[i].rs2;
      #1;
      chk("ready_a", i, 16'(ra), 16'(tv[i].era));
      chk("ready_b", i, 16'(rb), 16'(tv[i].erb));
      chk("hazard_stall", i, 16'(stall), 16'(tv[i].est));
      @(posedge clk); #1;
      chk("rd_addr_out", i, 16'(rd_addr), 16'(tv[i].eaddr));
      chk("rd_data_out", i, rd_data, tv[i].edata);
      chk("busy_vec", i, busy, tv[i].ebusy);
    end
    // both held valid from PRIO_A: grants alternate A, B, A, B
    @(negedge clk);
    av = 1; aa = 4'd1; ad = 16'hAAAA; bv = 1; ba = 4'd2; bd = 16'hBBBB; mv = 0; rs1 = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_ready_a", 100 + k, 16'(ra), 16'(k % 2 == 0));
      chk("alt_ready_b", 100 + k, 16'(rb), 16'(k % 2 == 1));
      @(posedge clk); #1;
      chk("alt_rd_addr", 100 + k, 16'(rd_addr), (k % 2 == 0) ? 16'd1 : 16'd2);
      chk("alt_rd_data", 100 + k, rd_data, (k % 2 == 0) ? 16'hAAAA : 16'hBBBB);
      @(negedge clk);
    end
    av = 0; bv = 0;
`ifdef RV16_WARB_PERF_EN
    #1;
    chk("conflict_count", 200, cc, 16'd4);
`endif
    @(posedge clk); #1;
    chk("idle_rd_addr", 201, 16'(rd_addr), 16'd0);
    chk("idle_rd_data_hold", 201, rd_data, 16'hBBBB);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/rv16_regfile_write_arbiter.md
Name: rv16_regfile_write_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: A (ALU) and B (load/CSR). Arbitration is round-robin, and the winning write is registered onto the write port. The block also keeps a 16-entry busy scoreboard of in-flight destinations, which the issue stage queries to stall on RAW hazards. It sits between the writeback sources and register_file. The register file writes whenever its address is non-zero, so the write port is idled by driving address 0.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (16 registers)

Ports:
- rv16_warb_clock  input  1  clock
- rv16_warb_reset  input  1  synchronous active-high reset
- req_a_valid  input  1  requester A has a write
- req_a_addr  input  ADDR_W  A destination register
- req_a_data  input  DATA_W  A write data
- req_a_ready  output  1  A accepted this cycle
- req_b_valid  input  1  requester B has a write
- req_b_addr  input  ADDR_W  B destination register
- req_b_data  input  DATA_W  B write data
- req_b_ready  output  1  B accepted this cycle
- mark_valid  input  1  issue stage allocates a destination
- mark_addr  input  ADDR_W  destination being allocated
- rs1_addr_in  input  ADDR_W  issue-stage source 1
- rs2_addr_in  input  ADDR_W  issue-stage source 2
- hazard_stall  output  1  rs1 or rs2 is busy
- rd_addr_out  output  ADDR_W  to register_file rd_addr_in
- rd_data_out  output  DATA_W  to register_file rd_reg_in
- busy_vec  output  16  scoreboard state, bit n = register n busy

Behaviour:
- Decided interface: one clock, rv16_warb_clock; reset rv16_warb_reset is synchronous and active-high.
- Reset values:
  - rd_addr_out=0, rd_data_out=0, busy_vec=0
  - priority pointer = PRIO_A
  - ready outputs are 0 while reset is asserted.
- Priority FSM has two states, PRIO_A and PRIO_B (the requester favoured next).
  - Only one valid: that requester is granted; the state does not change.
  - Both valid: the favoured requester is granted; the state flips to favour the other.
  - Neither valid: no grant; the state holds.
- Handshake:
  - ready is combinational from valid and the FSM state. At most one ready is high per cycle.
  - A transfer happens when valid and ready are both high.
  - A requester that is not granted must hold valid, addr and data stable until ready.
  - Throughput is one write per cycle.
- Write port:
  - Transfer in cycle N: rd_addr_out/rd_data_out show the granted addr/data from cycle N+1. The register file commits at the edge ending cycle N+1. Latency is 1 cycle.
  - No transfer in cycle N: rd_addr_out=0 in N+1; rd_data_out holds its previous value.
  - A transfer to address 0 is accepted normally and drives rd_addr_out=0, so nothing is written.
- Scoreboard:
  - mark_valid with a non-zero mark_addr sets busy[mark_addr] at the edge.
  - An accepted transfer clears busy[addr] at the edge ending the transfer cycle. The data is visible via the register-file bypass in the next cycle.
  - Mark and clear of the same address in the same cycle: mark wins and the bit stays 1, since it is a new in-flight producer.
  - busy[0] is always 0; marks to address 0 are ignored.
  - Mark of an already-busy register: the bit stays 1, with no error.
  - A transfer to a non-busy register is legal and leaves the bit 0.
- hazard_stall = busy[rs1_addr_in] | busy[rs2_addr_in]. It is combinational from the registered busy state. A same-cycle mark does not affect it.
- Reset mid-operation: all in-flight state is discarded, every busy bit clears, and rd_addr_out=0 on the next cycle. A transfer in the reset cycle is not written.

Optional Feature:
- Macro: RV16_WARB_PERF_EN.
- When defined:
  - Adds output conflict_count, 16 bits wide.
  - The counter increments by 1 in each non-reset cycle where both req_a_valid and req_b_valid are high.
  - It saturates at 16'hFFFF and resets to 0.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then A alone (addr 3, data 16'h1234) → req_a_ready=1 that cycle; next cycle rd_addr_out=3, rd_data_out=16'h1234; the cycle after that, rd_addr_out=0.
- A and B both valid for 4 cycles (A addr 5, B addr 6), each dropping valid after acceptance → grant order A, B. For a run with both held valid, grants alternate A, B, A, B starting from PRIO_A.
- mark_addr=7, then rs1_addr_in=7 → hazard_stall=1 from the next cycle until the cycle after B's transfer to 7, then hazard_stall=0 and busy_vec[7]=0.
- Same cycle: mark_addr=9 and A transfer to 9 with busy[9]=1 → busy[9] remains 1.
- mark_addr=0 and a transfer to addr 0 → busy_vec stays 0 and rd_addr_out=0, so no regfile write occurs.
- Reset asserted in the same cycle as a transfer to addr 4 with busy[4] set → next cycle rd_addr_out=0 and busy_vec=0. With RV16_WARB_PERF_EN, 3 dual-valid cycles → conflict_count=3.
